stop_watch_ctrl: RTL and testbench

Front-panel controller for the stopwatch. It synchronizes and debounces two asynchronous push-buttons, start/stop and lap/reset, and runs the run/pause/lap/clear state machine. It drives the counter's `cnt_en` and `clr` inputs and supplies a display-time bus that is either the live time or a frozen lap snapshot. It sits between the board buttons and the stopwatch counter, and its display bus feeds the seven-segment scan logic.

---
 rtl/stop_watch_ctrl.sv | 125 ++++++++++++
 tb/tb_stop_watch_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stop_watch_ctrl.sv
// Stopwatch front-panel controller: synchronizes and debounces the start/stop and
// lap/reset buttons, then runs the IDLE/RUN/LAP/STOP machine that drives the counter and display.
module stop_watch_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned TIME_W          = 23
) (
  input  logic              clk,
  input  logic              sys_rstn,
  input  logic              btn_ss,
  input  logic              btn_lr,
  input  logic [TIME_W-1:0] live_time,
  output logic              cnt_en,
  output logic              clr,
  output logic              disp_hold,
  output logic [TIME_W-1:0] disp_time,
  output logic [1:0]        state
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    STOP = 2'd3
  } state_t;

  // Bit 0 is the start/stop path, bit 1 the lap/reset path.
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       deb;
  logic [1:0]       deb_prev;
  logic [1:0]       press;
  logic [CNT_W-1:0] cnt [2];

  state_t           st;
  logic [TIME_W-1:0] snap;

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      deb_prev <= '0;
      press    <= '0;
      for (int unsigned i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sync1    <= {btn_lr, btn_ss};
      sync2    <= sync1;
      deb_prev <= deb;
      press    <= deb & ~deb_prev;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Start/stop is tested first in every state, so a coincident lap press is dropped.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      st        <= IDLE;
      cnt_en    <= 1'b0;
      disp_hold <= 1'b0;
      clr       <= 1'b0;
      snap      <= '0;
      disp_time <= '0;
    end else begin
      clr       <= 1'b0;
      disp_time <= live_time;
      case (st)
        IDLE: begin
          if (press[0]) begin
            st     <= RUN;
            cnt_en <= 1'b1;
          end else if (press[1]) begin
            clr <= 1'b1;
          end
        end
        RUN: begin
          if (press[0]) begin
            st     <= STOP;
            cnt_en <= 1'b0;
          end else if (press[1]) begin
            st        <= LAP;
            disp_hold <= 1'b1;
            snap      <= live_time;
          end
        end
        LAP: begin
          if (press[0]) begin
            st        <= STOP;
            cnt_en    <= 1'b0;
            disp_hold <= 1'b0;
          end else if (press[1]) begin
            st        <= RUN;
            disp_hold <= 1'b0;
          end else begin
            disp_time <= snap;
          end
        end
        STOP: begin
          if (press[0]) begin
            st     <= RUN;
            cnt_en <= 1'b1;
          end else if (press[1]) begin
            st  <= IDLE;
            clr <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Directed bench for stop_watch_ctrl with a short debounce window: a vector table for
// the press/transition sequence plus hand-written latency, bounce, lap, clear and collision cases.
module tb_stop_watch_ctrl;

  localparam int unsigned DEB = 16;
  localparam int unsigned TW  = 23;

  logic          clk = 1'b0;
  logic          sys_rstn;
  logic          btn_ss;
  logic          btn_lr;
  logic [TW-1:0] live_time;
  logic          cnt_en;
  logic          clr;
  logic          disp_hold;
  logic [TW-1:0] disp_time;
  logic [1:0]    state;

  stop_watch_ctrl #(.DEBOUNCE_CYCLES(DEB), .TIME_W(TW)) dut (
    .clk       (clk),
    .sys_rstn  (sys_rstn),
    .btn_ss    (btn_ss),
    .btn_lr    (btn_lr),
    .live_time (live_time),
    .cnt_en    (cnt_en),
    .clr       (clr),
    .disp_hold (disp_hold),
    .disp_time (disp_time),
    .state     (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ss;
    logic       lr;
    int         hold;
    logic [1:0] st;
    logic       en;
    logic       hd;
  } vec_t;

  vec_t vecs [10];

  int            n_cmp  = 0;
  int            n_fail = 0;
  int            clr_seen = 0;
  int            changes  = 0;
  logic [1:0]    prev_state = 2'd0;
  logic [TW-1:0] last_live = '0;
  bit            live_inc = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: outputs sampled 1 time unit after the edge; live_time advances afterwards.
  task automatic tick();
    logic [TW-1:0] pre;
    pre = live_time;
    @(posedge clk);
    #1;
    last_live = pre;
    if (live_inc) live_time = live_time + 1'b1;
    if (clr) clr_seen++;
    if (state != prev_state) changes++;
    prev_state = state;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input logic ss, input logic lr, input int hold);
    btn_ss = ss;
    btn_lr = lr;
    ticks(hold);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    ticks(24);
  endtask

  initial begin
    int n;
    int bad;
    int c0;
    bit found;
    logic [1:0]    st_at;
    logic [TW-1:0] snap_exp;

    vecs[0] = '{1'b1, 1'b0,  8, 2'd1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 24, 2'd3, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 24, 2'd1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 24, 2'd2, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 24, 2'd1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 24, 2'd2, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 24, 2'd3, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 24, 2'd0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 24, 2'd0, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 24, 2'd1, 1'b1, 1'b0};

    sys_rstn  = 1'b0;
    btn_ss    = 1'b0;
    btn_lr    = 1'b0;
    live_time = '0;
    ticks(3);
    sys_rstn = 1'b1;
    ticks(2);

    // Reset mid-debounce while running with a nonzero display.
    press(1'b1, 1'b0, 24);
    check("pre_reset_run", 32'(state), 32'd1);
    live_time = 23'h5A5A5;
    ticks(2);
    btn_ss = 1'b1;
    ticks(10);
    sys_rstn = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_cnt_en", 32'(cnt_en), 32'd0);
    check("rst_clr", 32'(clr), 32'd0);
    check("rst_hold", 32'(disp_hold), 32'd0);
    check("rst_disp", 32'(disp_time), 32'd0);
    btn_ss = 1'b0;
    live_time = '0;
    ticks(3);
    sys_rstn = 1'b1;
    ticks(100);
    check("post_rst_state", 32'(state), 32'd0);
    check("post_rst_cnt_en", 32'(cnt_en), 32'd0);

    // Press latency: the state update lands on the 20th edge.
    btn_ss = 1'b1;
    ticks(19);
    check("lat_edge19_state", 32'(state), 32'd0);
    tick();
    check("lat_edge20_state", 32'(state), 32'd1);
    check("lat_edge20_cnt_en", 32'(cnt_en), 32'd1);
    btn_ss = 1'b0;
    ticks(24);

    for (int v = 0; v < 10; v++) begin
      press(vecs[v].ss, vecs[v].lr, vecs[v].hold);
      check($sformatf("vec%0d_state", v), 32'(state), 32'(vecs[v].st));
      check($sformatf("vec%0d_cnt_en", v), 32'(cnt_en), 32'(vecs[v].en));
      check($sformatf("vec%0d_hold", v), 32'(disp_hold), 32'(vecs[v].hd));
    end

    // Bounce: 5-cycle pulses never survive the debounce window.
    c0 = changes;
    for (int p = 0; p < 20; p++) begin
      btn_ss = 1'b1;
      ticks(5);
      btn_ss = 1'b0;
      ticks(5);
    end
    ticks(20);
    check("bounce_no_change", 32'(changes - c0), 32'd0);
    check("bounce_state", 32'(state), 32'd1);
    btn_ss = 1'b1;
    ticks(17);
    btn_ss = 1'b0;
    ticks(40);
    check("stable17_one_change", 32'(changes - c0), 32'd1);
    check("stable17_state", 32'(state), 32'd3);

    // Lap freeze with a running live counter.
    press(1'b1, 1'b0, 24);
    live_inc = 1'b1;
    btn_lr = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (state == 2'd2) found = 1'b1;
    end
    check("lap_entry_reached", 32'(found), 32'd1);
    snap_exp = last_live;
    check("lap_entry_disp", 32'(disp_time), 32'(snap_exp));
    check("lap_hold", 32'(disp_hold), 32'd1);
    check("lap_cnt_en", 32'(cnt_en), 32'd1);
    btn_lr = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (disp_time !== snap_exp || cnt_en !== 1'b1) bad++;
    end
    check("lap_frozen", 32'(bad), 32'd0);
    btn_lr = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (state == 2'd1) found = 1'b1;
    end
    check("lap_exit_reached", 32'(found), 32'd1);
    check("lap_exit_hold", 32'(disp_hold), 32'd0);
    check("lap_exit_disp", 32'(disp_time), 32'(last_live));
    btn_lr = 1'b0;
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (disp_time !== last_live) bad++;
    end
    check("run_disp_lag1", 32'(bad), 32'd0);
    live_inc = 1'b0;

    // Clear from STOP, then again from IDLE.
    press(1'b1, 1'b0, 24);
    check("clr_pre_stop", 32'(state), 32'd3);
    for (int k = 0; k < 2; k++) begin
      btn_lr = 1'b1;
      n = 0;
      st_at = 2'd3;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (clr) begin
          n++;
          st_at = state;
        end
      end
      btn_lr = 1'b0;
      ticks(24);
      check($sformatf("clr%0d_pulses", k), 32'(n), 32'd1);
      check($sformatf("clr%0d_state", k), 32'(st_at), 32'd0);
    end

    // Simultaneous presses in RUN: start/stop wins, lap press is dropped.
    press(1'b1, 1'b0, 24);
    check("sim_pre_run", 32'(state), 32'd1);
    c0 = changes;
    n = clr_seen;
    btn_ss = 1'b1;
    btn_lr = 1'b1;
    ticks(24);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    ticks(80);
    check("sim_state", 32'(state), 32'd3);
    check("sim_no_clr", 32'(clr_seen - n), 32'd0);
    check("sim_hold", 32'(disp_hold), 32'd0);
    check("sim_one_change", 32'(changes - c0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
